ibex_if_id_handoff: RTL and testbench
=====================================

// Module: ibex_if_id_handoff
// PURPOSE
// - Producer side of the IF->ID instruction interface: buffers fetched instructions and presents them to the ID stage.
// - Drives instr_valid/instr_new/rdata/compressed/fetch_err/pc_id to ID.
// - Obeys ID's id_in_ready and instr_valid_clear, and the controller's pc_set flush.
// - Sits between the prefetch unit and ibex_id_stage.
// PARAMETERS
// - DEPTH  2  fetch FIFO entries (>=1); each entry is {rdata[31:0], addr[31:0], err}
// PORTS
// - clk_i                  in   1   clock
// - rst_i                  in   1   reset, asynchronous, active-high
// - fetch_valid_i          in   1   prefetch has an aligned instruction (low half at [15:0])
// - fetch_ready_o          out  1   FIFO can accept (registered; =!full)
// - fetch_rdata_i          in   32  instruction bits
// - fetch_addr_i           in   32  instruction PC
// - fetch_err_i            in   1   bus error on this fetch
// - pc_set_i               in   1   controller redirect; flush everything
// - id_in_ready_i          in   1   ID will consume the next instruction this cycle
// - instr_valid_clear_i    in   1   ID retires/kills the instruction in the ID register
// - instr_valid_id_o       out  1   ID register holds a valid instruction
// - instr_new_id_o         out  1   one-cycle pulse, first cycle of a newly loaded instruction
// - instr_rdata_id_o       out  32  ID register instruction
// - instr_rdata_c_id_o     out  16  instr_rdata_id_o[15:0]
// - instr_is_compressed_id_o out 1  instr_rdata_id_o[1:0] != 2'b11
// - instr_fetch_err_o      out  1   ID register entry carries a fetch error
// - pc_id_o                out  32  PC of ID register instruction
// - perf_if_bubble_o       out  32  bubble counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset: FIFO empty, pointers 0; all ID outputs 0; fetch_ready_o=1 once reset is released; counter 0.
// - FIFO push: fetch_valid_i & fetch_ready_o & !pc_set_i.
// - Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
// - Push and pop in the same cycle when full is legal; count is unchanged.
// - Load (ID register <= next): id_in_ready_i & !pc_set_i & (FIFO non-empty | push).
//   - The source is the FIFO head.
//   - If the FIFO is empty, the incoming fetch bypasses it (zero-latency pass-through); that entry is not stored.
// - On load: instr_valid_id_o=1 and instr_new_id_o=1 in the next cycle only. The register holds until the next load.
// - instr_valid_clear_i: instr_valid_id_o<=0 next cycle unless a load occurs the same cycle (load wins: the new entry is valid).
// - pc_set_i: highest priority.
//   - FIFO emptied, valid and new cleared next cycle.
//   - Same-cycle fetch input and load are discarded.
//   - rdata/pc/err registers keep their old value.
// - instr_new_id_o is never high while instr_valid_id_o=0.
// - Fetch error entries propagate like normal entries (err flag travels with the entry); no special stall.
// - Reset asserted mid-operation: immediate async return to reset values; in-flight entries lost.
// CONFIGURATION
// - Macro IBEX_IF_BUBBLE_CNT_EN.
// - Defined: perf_if_bubble_o is a 32-bit saturating counter.
//   - Increments each cycle with id_in_ready_i & !pc_set_i & no load.
//   - Holds at 32'hFFFF_FFFF; cleared only by reset.
// - Undefined: port tied to 32'h0, no flops.
// STRUCTURE
// - ibex_pkg gains:
//   - fetch_entry_t struct {rdata[31:0], addr[31:0], err}
//   - constant INSTR_UNCOMPRESSED = 2'b11
// - Sub-module ibex_fetch_fifo: DEPTH entries of fetch_entry_t; push/pop/flush/full/empty/head.
// - The top level holds the ID register, bypass mux, flush priority and optional counter.
// TESTING
// - Reset, then fetch 0x00000013 @0x80 with ready=1 -> next cycle valid=1, new=1, pc_id=0x80; following cycle new=0.
// - id_in_ready=0, push 3 words with DEPTH=2 -> fetch_ready_o=0 after 2; ready=1 -> pops in order, ready returns next cycle.
// - Instruction 0x4501 -> instr_is_compressed_id_o=1, instr_rdata_c_id_o=0x4501.
// - 0x00A00093 -> instr_is_compressed_id_o=0.
// - pc_set_i with full FIFO and valid ID register -> next cycle valid=0, empty, fetch_ready_o=1; same-cycle fetch dropped.
// - instr_valid_clear_i and load same cycle -> valid stays 1, new=1, new pc shown.
// - fetch_err_i=1 entry -> instr_fetch_err_o=1 while that entry is in ID.
// - With IBEX_IF_BUBBLE_CNT_EN: 5 ready cycles with empty FIFO and no fetch -> perf_if_bubble_o=5.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types and constants for the IF->ID handoff slice.
package ibex_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } fetch_entry_t;

    localparam logic [1:0] INSTR_UNCOMPRESSED = 2'b11;

endpackage

// File: rtl/ibex_fetch_fifo.sv
// Small circular fetch FIFO holding fetch_entry_t words; head is the oldest entry.
module ibex_fetch_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];

    // A push while full is only accepted when it is paired with a pop.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ibex_if_id_handoff.sv
// IF->ID producer: fetch FIFO, bypass path, ID register and flush priority.
// Optional bubble counter enabled by defining IBEX_IF_BUBBLE_CNT_EN.
module ibex_if_id_handoff
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_err_i,
    input  logic        pc_set_i,
    input  logic        id_in_ready_i,
    input  logic        instr_valid_clear_i,
    output logic        instr_valid_id_o,
    output logic        instr_new_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [15:0] instr_rdata_c_id_o,
    output logic        instr_is_compressed_id_o,
    output logic        instr_fetch_err_o,
    output logic [31:0] pc_id_o,
    output logic [31:0] perf_if_bubble_o
);

    fetch_entry_t fetch_in, fifo_head, load_entry;
    logic         fifo_full, fifo_empty;
    logic         push_req, load;
    logic         valid_q, valid_d, new_q;
    fetch_entry_t id_q;

    assign fetch_in      = '{rdata: fetch_rdata_i, addr: fetch_addr_i, err: fetch_err_i};
    assign fetch_ready_o = ~fifo_full;
    assign push_req      = fetch_valid_i & fetch_ready_o & ~pc_set_i;
    assign load          = id_in_ready_i & ~pc_set_i & (~fifo_empty | push_req);
    // With an empty FIFO the incoming fetch goes straight to ID and is not stored.
    assign load_entry    = fifo_empty ? fetch_in : fifo_head;

    ibex_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req & ~(load & fifo_empty)),
        .pop_i   (load & ~fifo_empty),
        .flush_i (pc_set_i),
        .wdata_i (fetch_in),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        valid_d = valid_q;
        if (pc_set_i)                 valid_d = 1'b0;
        else if (load)                valid_d = 1'b1;
        else if (instr_valid_clear_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            new_q   <= load;
            if (load) id_q <= load_entry;
        end
    end

    assign instr_valid_id_o         = valid_q;
    assign instr_new_id_o           = new_q;
    assign instr_rdata_id_o         = id_q.rdata;
    assign instr_rdata_c_id_o       = id_q.rdata[15:0];
    assign instr_is_compressed_id_o = (id_q.rdata[1:0] != INSTR_UNCOMPRESSED);
    assign instr_fetch_err_o        = id_q.err;
    assign pc_id_o                  = id_q.addr;

`ifdef IBEX_IF_BUBBLE_CNT_EN
    logic [31:0] bubble_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_q <= '0;
        end else if (id_in_ready_i && !pc_set_i && !load && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign perf_if_bubble_o = bubble_q;
`else
    assign perf_if_bubble_o = 32'h0;
`endif

endmodule

// File: tb/tb_ibex_if_id_handoff.sv
// Directed bench for ibex_if_id_handoff with a queue-based reference model.
module tb_ibex_if_id_handoff;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_rdata = '0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_err = 1'b0;
    logic        pc_set = 1'b0;
    logic        id_in_ready = 1'b0;
    logic        valid_clear = 1'b0;
    logic        instr_valid, instr_new, is_compressed, fetch_err_id;
    logic [31:0] rdata_id, pc_id, perf;
    logic [15:0] rdata_c;

    always #5 clk = ~clk;

    ibex_if_id_handoff #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .fetch_valid_i            (fetch_valid),
        .fetch_ready_o            (fetch_ready),
        .fetch_rdata_i            (fetch_rdata),
        .fetch_addr_i             (fetch_addr),
        .fetch_err_i              (fetch_err),
        .pc_set_i                 (pc_set),
        .id_in_ready_i            (id_in_ready),
        .instr_valid_clear_i      (valid_clear),
        .instr_valid_id_o         (instr_valid),
        .instr_new_id_o           (instr_new),
        .instr_rdata_id_o         (rdata_id),
        .instr_rdata_c_id_o       (rdata_c),
        .instr_is_compressed_id_o (is_compressed),
        .instr_fetch_err_o        (fetch_err_id),
        .pc_id_o                  (pc_id),
        .perf_if_bubble_o         (perf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue for the FIFO plus the ID register contents.
    typedef struct {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } ent_t;

    ent_t        m_fifo[$];
    ent_t        m_in, m_ent;
    logic        m_valid, m_new, m_err;
    logic [31:0] m_rdata, m_pc;
    longint unsigned m_perf;
    bit          m_push, m_load;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_valid = 0; m_new = 0; m_err = 0; m_rdata = 0; m_pc = 0; m_perf = 0;
        end else begin
            m_in   = '{rdata: fetch_rdata, addr: fetch_addr, err: fetch_err};
            m_push = fetch_valid && (m_fifo.size() < DEPTH) && !pc_set;
            m_load = id_in_ready && !pc_set && (m_fifo.size() > 0 || m_push);
            if (id_in_ready && !pc_set && !m_load && m_perf != 64'hFFFF_FFFF) m_perf++;
            if (pc_set) begin
                m_fifo.delete();
                m_valid = 0;
                m_new   = 0;
            end else if (m_load) begin
                if (m_fifo.size() > 0) begin
                    m_ent = m_fifo.pop_front();
                    if (m_push) m_fifo.push_back(m_in);
                end else begin
                    m_ent = m_in;
                end
                m_rdata = m_ent.rdata; m_pc = m_ent.addr; m_err = m_ent.err;
                m_valid = 1; m_new = 1;
            end else begin
                if (m_push) m_fifo.push_back(m_in);
                m_new = 0;
                if (valid_clear) m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_ready", {31'b0, fetch_ready}, {31'b0, m_fifo.size() < DEPTH});
            check("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
            check("m_new", {31'b0, instr_new}, {31'b0, m_new});
            check("m_rdata", rdata_id, m_rdata);
            check("m_rdata_c", {16'b0, rdata_c}, {16'b0, m_rdata[15:0]});
            check("m_compr", {31'b0, is_compressed}, {31'b0, m_rdata[1:0] != 2'b11});
            check("m_err", {31'b0, fetch_err_id}, {31'b0, m_err});
            check("m_pc", pc_id, m_pc);
            check("new_implies_valid", {31'b0, instr_new & ~instr_valid}, 32'd0);
`ifdef IBEX_IF_BUBBLE_CNT_EN
            check("m_perf", perf, m_perf[31:0]);
`else
            check("m_perf", perf, 32'd0);
`endif
        end
    end

    // Apply inputs for one cycle, then land just after the following falling edge.
    task automatic tick(input logic v, input logic [31:0] d, input logic [31:0] a,
                        input logic e, input logic idr, input logic clr, input logic ps);
        fetch_valid = v; fetch_rdata = d; fetch_addr = a; fetch_err = e;
        id_in_ready = idr; valid_clear = clr; pc_set = ps;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_ready", {31'b0, fetch_ready}, 32'd1);
        check("rst_pc", pc_id, 32'd0);
        rst = 1'b0;

        tick(1, 32'h0000_0013, 32'h80, 0, 1, 0, 0);
        check("first_valid", {31'b0, instr_valid}, 32'd1);
        check("first_new", {31'b0, instr_new}, 32'd1);
        check("first_pc", pc_id, 32'h80);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("first_new_drop", {31'b0, instr_new}, 32'd0);

        tick(1, 32'h0000_4501, 32'h84, 0, 0, 0, 0);
        check("one_ready", {31'b0, fetch_ready}, 32'd1);
        tick(1, 32'h00A0_0093, 32'h86, 0, 0, 0, 0);
        check("full_ready", {31'b0, fetch_ready}, 32'd0);
        tick(1, 32'h1111_1111, 32'h8A, 0, 0, 0, 0);
        check("full_hold", {31'b0, fetch_ready}, 32'd0);
        tick(1, 32'h1111_1111, 32'h8A, 0, 1, 0, 0);
        check("pop1_pc", pc_id, 32'h84);
        check("pop1_compr", {31'b0, is_compressed}, 32'd1);
        check("pop1_rdata_c", {16'b0, rdata_c}, 32'h4501);
        check("pop1_ready", {31'b0, fetch_ready}, 32'd1);
        tick(1, 32'h1111_1111, 32'h8A, 0, 1, 0, 0);
        check("pop2_pc", pc_id, 32'h86);
        check("pop2_compr", {31'b0, is_compressed}, 32'd0);

        tick(1, 32'h0000_0033, 32'h90, 1, 0, 0, 0);
        check("refill_full", {31'b0, fetch_ready}, 32'd0);
        tick(1, 32'h0000_0055, 32'hA0, 0, 1, 0, 1);
        check("flush_valid", {31'b0, instr_valid}, 32'd0);
        check("flush_ready", {31'b0, fetch_ready}, 32'd1);
        check("flush_pc_kept", pc_id, 32'h86);
        tick(0, 0, 0, 0, 1, 0, 0);
        check("flush_empty", {31'b0, instr_valid}, 32'd0);

        tick(1, 32'h0000_0033, 32'h90, 1, 1, 0, 0);
        check("err_flag", {31'b0, fetch_err_id}, 32'd1);
        check("err_pc", pc_id, 32'h90);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("err_hold", {31'b0, fetch_err_id}, 32'd1);

        tick(1, 32'h0000_0044, 32'h94, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 1, 0);
        check("clr_load_valid", {31'b0, instr_valid}, 32'd1);
        check("clr_load_new", {31'b0, instr_new}, 32'd1);
        check("clr_load_pc", pc_id, 32'h94);
        tick(0, 0, 0, 0, 0, 1, 0);
        check("clr_valid", {31'b0, instr_valid}, 32'd0);

        tick(1, 32'h0000_0066, 32'h98, 0, 1, 0, 0);
        tick(1, 32'h0000_0077, 32'h9C, 0, 0, 0, 0);
        fetch_valid = 0; id_in_ready = 0;
        rst = 1'b1;
        #1;
        check("async_valid", {31'b0, instr_valid}, 32'd0);
        check("async_pc", pc_id, 32'd0);
        check("async_ready", {31'b0, fetch_ready}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;

        repeat (5) tick(0, 0, 0, 0, 1, 0, 0);
        check("bubble_valid", {31'b0, instr_valid}, 32'd0);
`ifdef IBEX_IF_BUBBLE_CNT_EN
        check("bubble_cnt", perf, 32'd5);
`else
        check("bubble_cnt", perf, 32'd0);
`endif
        tick(0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
